pdu_lqscheduler: RTL and testbench
==================================

Name: pdu_lqscheduler

Overview:
- Sequences a per-instruction logical-qubit bitmap, one logical-qubit index per cycle, to the downstream PDU patch-decoding stage.
- Accepts a NUM_LQ-bit list over a load handshake and registers it.
- Issues indices lowest-set-bit first over a valid/ready handshake, clearing each bit as it is issued.
- Signals completion with a one-cycle done pulse, then returns to idle for the next list.

Parameters:
- NUM_LQ, 16, number of logical qubits (width of the list).
- LQADDR_BW, 4, index width; must be at least ceil(log2(NUM_LQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a new lqlist is presented.
- in_ready  output  1  scheduler can accept a list; equals (state==IDLE).
- in_lqlist  input  NUM_LQ  bitmap of logical qubits to visit; bit i set means index i is pending.
- out_valid  output  1  out_lqidx is valid.
- out_ready  input  1  consumer accepts out_lqidx this cycle.
- out_lqidx  output  LQADDR_BW  index currently offered.
- out_last  output  1  qualifies out_valid; the offered index is the final one in the list.
- done  output  1  one-cycle pulse after a list is fully issued, or immediately for an empty list.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), reset rst_n. Reset values:
  - state = IDLE; the list register is all zeros.
  - in_ready = 1; out_valid = 0; out_lqidx = 0; out_last = 0; done = 0; busy = 0.
- Reset asserted mid-list drops all pending bits immediately. No done pulse is produced for the aborted list.
- State IDLE:
  - in_ready = 1.
  - On in_valid, latch in_lqlist into the list register.
  - If in_lqlist is non-zero, go to ISSUE; if it is zero, go to DONE.
- State ISSUE:
  - out_valid = 1.
  - out_lqidx = index of the lowest set bit of the list register. This is combinational from the register, so latency from load to first valid index is 1 cycle.
  - out_last = 1 when exactly one bit remains set.
  - Handshake occurs on out_valid & out_ready:
    - clear the bit at out_lqidx;
    - if out_last, go to DONE; otherwise stay in ISSUE with the next lowest index on the following cycle.
  - Without a handshake, out_lqidx and out_last hold stable. Backpressure may last any number of cycles.
  - Throughput: one index per cycle while out_ready stays high. A list with K set bits completes in K issue cycles plus 1 done cycle.
- State DONE:
  - done = 1 for exactly one cycle, then go to IDLE.
  - in_ready = 0 in DONE, so back-to-back lists have a minimum gap of 1 cycle.
- Boundary conditions:
  - in_valid while not in IDLE is ignored; in_ready = 0 in those states.
  - An all-ones list issues indices 0..NUM_LQ-1 in order; out_last is set only on NUM_LQ-1.
  - A single bit at position NUM_LQ-1 issues NUM_LQ-1 with out_last = 1.
  - Index arithmetic is unsigned and never exceeds NUM_LQ-1. There is no wrap-around.

Optional Feature:
- Macro: PDU_LQSCHED_CNT_EN.
- When defined, add output issue_cnt, width LQADDR_BW+1:
  - resets to 0 and clears to 0 on each accepted load;
  - increments on every out handshake;
  - holds its final value through DONE and IDLE until the next load.
- When not defined, the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- Reset check: rst_n low for 3 cycles, released asynchronously mid-cycle -> in_ready=1, out_valid=0, done=0, busy=0.
- Sparse list, out_ready held 1, in_lqlist=16'h8421 -> out_lqidx 0,5,10,15 on consecutive cycles; out_last only on 15; done pulses the next cycle; issue_cnt=4 when CNT_EN is defined.
- Empty list, in_lqlist=0 -> no out_valid; done pulses 1 cycle after the load; in_ready returns to 1 the cycle after that.
- Backpressure, in_lqlist=16'h0006, out_ready low for 3 cycles then high -> out_lqidx=1 held stable for 4 cycles, then 2 with out_last=1, then done.
- Ignored load: in_valid with 16'hFFFF asserted while ISSUE is busy with 16'h0003 -> only indices 0 and 1 are issued; the second list is not taken until IDLE.
- Mid-list reset: rst_n pulled low after index 3 of 16'h00F8 is issued -> out_valid drops immediately; no done pulse; after release in_ready=1 and the list register is 0.

Source files
------------

// File: rtl/pdu_lqscheduler.sv
// pdu_lqscheduler: issues a logical-qubit bitmap to the patch decoder as a stream of indices, lowest set bit first.
// Latency: first index is valid 1 cycle after load; one index per cycle; done pulses 1 cycle after the last index.
// Backpressure: out_ready low holds out_lqidx/out_last stable indefinitely; in_ready is high only in IDLE.
// Optional: define PDU_LQSCHED_CNT_EN to add the issue_cnt output.
module pdu_lqscheduler #(
  parameter int NUM_LQ    = 16,
  parameter int LQADDR_BW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_LQ-1:0]    in_lqlist,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LQADDR_BW-1:0] out_lqidx,
  output logic                 out_last,
  output logic                 done,
  output logic                 busy
`ifdef PDU_LQSCHED_CNT_EN
  ,
  output logic [LQADDR_BW:0]   issue_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_LQ-1:0]   lqlist;
  logic [NUM_LQ-1:0]   lqlist_minus1;
  logic [LQADDR_BW-1:0] lowest_idx;
  logic                one_left;
  logic                out_hs;

  // Descending scan so the last assignment wins: the lowest set bit.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_LQ - 1; i >= 0; i--) begin
      if (lqlist[i]) lowest_idx = LQADDR_BW'(i);
    end
  end

  // x & (x-1) drops the lowest set bit; zero result means at most one bit was set.
  assign lqlist_minus1 = lqlist - NUM_LQ'(1);
  assign one_left      = (lqlist != '0) && ((lqlist & lqlist_minus1) == '0);

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == ISSUE);
  assign out_lqidx = lowest_idx;
  assign out_last  = (state == ISSUE) && one_left;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lqlist <= '0;
`ifdef PDU_LQSCHED_CNT_EN
      issue_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lqlist <= in_lqlist;
            state  <= (in_lqlist != '0) ? ISSUE : DONE;
`ifdef PDU_LQSCHED_CNT_EN
            issue_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          if (out_hs) begin
            lqlist <= lqlist & lqlist_minus1;
            if (one_left) state <= DONE;
`ifdef PDU_LQSCHED_CNT_EN
            issue_cnt <= issue_cnt + {{LQADDR_BW{1'b0}}, 1'b1};
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdu_lqscheduler.sv
// Self-checking bench for pdu_lqscheduler: directed table, corner sequences, randomized lists vs a queue model.
module tb_pdu_lqscheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_lqlist;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_lqidx;
  logic        out_last;
  logic        done;
  logic        busy;
`ifdef PDU_LQSCHED_CNT_EN
  logic [4:0]  issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdu_lqscheduler #(.NUM_LQ(16), .LQADDR_BW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_lqlist(in_lqlist),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lqidx(out_lqidx),
    .out_last (out_last),
    .done     (done),
    .busy     (busy)
`ifdef PDU_LQSCHED_CNT_EN
    ,
    .issue_cnt(issue_cnt)
`endif
  );

  typedef struct {
    logic [15:0] lst;
    int          exp_k;
    int          exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: expected issue order is simply the ascending list of set bit positions.
  task automatic run_list(input logic [15:0] l, input bit rnd, output int ncyc, output int first_idx);
    int q[$];
    int guard;
    bit rdy;
    for (int i = 0; i < 16; i++) if (l[i]) q.push_back(i);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_lqlist = l;
    tick();
    first_idx = int'(out_lqidx);
    in_valid  = rnd ? 1'($urandom) : 1'b0;
    in_lqlist = 16'($urandom);
    ncyc  = 0;
    guard = 0;
    while (q.size() > 0 && guard < 400) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_lqidx", 32'(out_lqidx), 32'(q[0]));
      chk("out_last", 32'(out_last), 32'(q.size() == 1));
      chk("busy_issue", 32'(busy), 32'd1);
      chk("in_ready_issue", 32'(in_ready), 32'd0);
      chk("done_issue", 32'(done), 32'd0);
      rdy = rnd ? ($urandom % 3 != 0) : 1'b1;
      out_ready = rdy;
      if (rdy) void'(q.pop_front());
      tick();
      ncyc++;
      guard++;
      if (rnd) begin
        in_valid  = 1'($urandom);
        in_lqlist = 16'($urandom);
      end
    end
    chk("issue_timeout", 32'(q.size()), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd0);
`ifdef PDU_LQSCHED_CNT_EN
    chk("issue_cnt", 32'(issue_cnt), 32'($countones(l)));
`endif
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("done_clear", 32'(done), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("out_valid_idle", 32'(out_valid), 32'd0);
`ifdef PDU_LQSCHED_CNT_EN
    chk("issue_cnt_hold", 32'(issue_cnt), 32'($countones(l)));
`endif
  endtask

  initial begin
    int ncyc;
    int fidx;
    logic [15:0] rl;

    vecs[0] = '{16'h8421, 4, 0};
    vecs[1] = '{16'h0000, 0, 0};
    vecs[2] = '{16'hFFFF, 16, 0};
    vecs[3] = '{16'h8000, 1, 15};
    vecs[4] = '{16'h0006, 2, 1};
    vecs[5] = '{16'h0001, 1, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_lqlist = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_lqidx", 32'(out_lqidx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    tick();

    for (int v = 0; v < 6; v++) begin
      run_list(vecs[v].lst, 1'b0, ncyc, fidx);
      chk("vec_cycles", 32'(ncyc), 32'(vecs[v].exp_k));
      chk("vec_first", 32'(fidx), 32'(vecs[v].exp_first));
    end

    // Backpressure: index 1 held for 3 stalled cycles plus the accepting one.
    in_valid = 1'b1; in_lqlist = 16'h0006; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_idx", 32'(out_lqidx), 32'd1);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_idx1", 32'(out_lqidx), 32'd1);
    tick();
    chk("bp_idx2", 32'(out_lqidx), 32'd2);
    chk("bp_last2", 32'(out_last), 32'd1);
    tick();
    chk("bp_done", 32'(done), 32'd1);
    out_ready = 1'b0;
    tick();
    chk("bp_in_ready", 32'(in_ready), 32'd1);

    // Ignored load while busy; the held in_valid is only taken once back in IDLE.
    in_valid = 1'b1; in_lqlist = 16'h0003; out_ready = 1'b1;
    tick();
    in_lqlist = 16'hFFFF;
    chk("ign_idx0", 32'(out_lqidx), 32'd0);
    chk("ign_last0", 32'(out_last), 32'd0);
    chk("ign_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("ign_idx1", 32'(out_lqidx), 32'd1);
    chk("ign_last1", 32'(out_last), 32'd1);
    tick();
    chk("ign_done", 32'(done), 32'd1);
    tick();
    chk("ign_idle", 32'(in_ready), 32'd1);
    chk("ign_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("ign_new_valid", 32'(out_valid), 32'd1);
    chk("ign_new_idx", 32'(out_lqidx), 32'd0);
    chk("ign_new_last", 32'(out_last), 32'd0);
    repeat (16) tick();
    chk("ign_new_done", 32'(done), 32'd1);
    tick();
    chk("ign_new_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of a list aborts it with no done pulse.
    in_valid = 1'b1; in_lqlist = 16'h00F8; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr_idx3", 32'(out_lqidx), 32'd3);
    tick();
    chk("mr_idx4", 32'(out_lqidx), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_done_after", 32'(done), 32'd0);
    chk("mr_list_idx", 32'(out_lqidx), 32'd0);
    chk("mr_list_last", 32'(out_last), 32'd0);
`ifdef PDU_LQSCHED_CNT_EN
    chk("mr_issue_cnt", 32'(issue_cnt), 32'd0);
`endif
    out_ready = 1'b0;

    for (int r = 0; r < 40; r++) begin
      case ($urandom % 4)
        0: rl = 16'd1 << ($urandom % 16);
        1: rl = 16'($urandom) & 16'($urandom);
        2: rl = 16'($urandom);
        default: rl = ($urandom % 4 == 0) ? 16'h0000 : (16'hFFFF ^ (16'd1 << ($urandom % 16)));
      endcase
      run_list(rl, 1'b1, ncyc, fidx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
